// File: rtl/tennis_pkg.sv
// rtl/tennis_pkg.sv - shared constants, state encoding and scoring helpers for the tennis scorer
package tennis_pkg;

  localparam logic [6:0] ZERO  = 7'b0111111;
  localparam logic [6:0] ONE   = 7'b0000110;
  localparam logic [6:0] TWO   = 7'b1011011;
  localparam logic [6:0] THREE = 7'b1001111;
  localparam logic [6:0] FOUR  = 7'b1100110;
  localparam logic [6:0] FIVE  = 7'b1101101;
  localparam logic [6:0] SIX   = 7'b1111101;
  localparam logic [6:0] SEVEN = 7'b0000111;
  localparam logic [6:0] EIGHT = 7'b1111111;
  localparam logic [6:0] NINE  = 7'b1101111;
  localparam logic [6:0] LET_A = 7'b1110111;
  localparam logic [6:0] LET_d = 7'b1011110;
  localparam logic [6:0] BLANK = 7'b0000000;

  localparam logic [2:0] PT_0  = 3'd0;
  localparam logic [2:0] PT_15 = 3'd1;
  localparam logic [2:0] PT_30 = 3'd2;
  localparam logic [2:0] PT_40 = 3'd3;
  localparam logic [2:0] PT_AD = 3'd4;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    GAME_HOLD = 2'd1,
    SET_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] AN_NORMAL = 8'b1011_1101;

  // Point won by A against B; result is {game_to_a, new_pa, new_pb}.
  function automatic logic [6:0] point_step(input logic [2:0] pa, input logic [2:0] pb);
    logic [6:0] r;
    r = {1'b0, pa, pb};
    if (pa < PT_40) begin
      r = {1'b0, pa + 3'd1, pb};
    end else if (pa == PT_40) begin
      if (pb < PT_40)       r = {1'b1, PT_0, PT_0};
      else if (pb == PT_40) r = {1'b0, PT_AD, PT_40};
      else                  r = {1'b0, PT_40, PT_40};
    end else begin
      r = {1'b1, PT_0, PT_0};
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = ZERO;
      4'd1:    s = ONE;
      4'd2:    s = TWO;
      4'd3:    s = THREE;
      4'd4:    s = FOUR;
      4'd5:    s = FIVE;
      4'd6:    s = SIX;
      4'd7:    s = SEVEN;
      4'd8:    s = EIGHT;
      4'd9:    s = NINE;
      default: s = BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tennis_digit_enc.sv
// rtl/tennis_digit_enc.sv - point code to two-digit pattern and 0..9 value to one-digit pattern
module tennis_digit_enc
  import tennis_pkg::*;
(
  input  logic [2:0] i_pt,
  input  logic [3:0] i_val,
  output logic [6:0] o_pt_hi,
  output logic [6:0] o_pt_lo,
  output logic [6:0] o_val
);

  always_comb begin
    o_pt_hi = BLANK;
    o_pt_lo = BLANK;
    case (i_pt)
      PT_0:    begin o_pt_hi = ZERO;  o_pt_lo = ZERO;  end
      PT_15:   begin o_pt_hi = ONE;   o_pt_lo = FIVE;  end
      PT_30:   begin o_pt_hi = THREE; o_pt_lo = ZERO;  end
      PT_40:   begin o_pt_hi = FOUR;  o_pt_lo = ZERO;  end
      PT_AD:   begin o_pt_hi = LET_A; o_pt_lo = LET_d; end
      default: begin o_pt_hi = BLANK; o_pt_lo = BLANK; end
    endcase
    o_val = digit_seg(i_val);
  end

endmodule

// File: rtl/tennis_score_ctrl.sv
// rtl/tennis_score_ctrl.sv - tennis point/game/set scoring with registered seven-segment outputs
module tennis_score_ctrl
  import tennis_pkg::*;
#(
  parameter int GAMES_TO_WIN = 6,
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        point1,
  input  logic        point2,
  output logic [7:0]  an_en,
  output logic [55:0] seg_data,
  output logic [1:0]  winner,
  output logic        game_pulse
);

  localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [3:0] GAMES_WIN = GAMES_TO_WIN[3:0];
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  generate
    if (GAMES_TO_WIN < 1 || GAMES_TO_WIN > 9) begin : g_bad_games
      $error("GAMES_TO_WIN must be 1..9 for a single games digit");
    end
  endgenerate

  state_t             r_state, w_state_nx;
  logic               r_prev1, r_prev2;
  logic [2:0]         r_p1, r_p2, w_p1_nx, w_p2_nx;
  logic [3:0]         r_g1, r_g2, w_g1_nx, w_g2_nx;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nx;
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nx;
  logic               r_blink, w_blink_nx;
  logic               r_game_pulse, w_pulse_nx;
  logic [55:0]        r_seg_data;
  logic [7:0]         r_an_en, w_an;
  logic [1:0]         r_winner, w_winner;

  logic w_rise1, w_rise2, w_ev1, w_ev2;
  logic [6:0] w_step1, w_step2;
  logic [6:0] w_p1_hi, w_p1_lo, w_g1_seg, w_p2_hi, w_p2_lo, w_g2_seg;

  // Simultaneous rising edges cancel each other out.
  assign w_rise1 = point1 & ~r_prev1;
  assign w_rise2 = point2 & ~r_prev2;
  assign w_ev1   = w_rise1 & ~w_rise2;
  assign w_ev2   = w_rise2 & ~w_rise1;
  assign w_step1 = point_step(r_p1, r_p2);
  assign w_step2 = point_step(r_p2, r_p1);

  always_comb begin
    w_state_nx     = r_state;
    w_p1_nx        = r_p1;
    w_p2_nx        = r_p2;
    w_g1_nx        = r_g1;
    w_g2_nx        = r_g2;
    w_hold_nx      = r_hold_cnt;
    w_blink_cnt_nx = r_blink_cnt;
    w_blink_nx     = r_blink;
    w_pulse_nx     = 1'b0;
    case (r_state)
      PLAY: begin
        if (w_ev1) begin
          w_p1_nx = w_step1[5:3];
          w_p2_nx = w_step1[2:0];
          if (w_step1[6]) begin
            w_g1_nx    = r_g1 + 4'd1;
            w_pulse_nx = 1'b1;
            w_hold_nx  = '0;
            w_state_nx = (w_g1_nx == GAMES_WIN) ? SET_DONE : GAME_HOLD;
          end
        end else if (w_ev2) begin
          w_p2_nx = w_step2[5:3];
          w_p1_nx = w_step2[2:0];
          if (w_step2[6]) begin
            w_g2_nx    = r_g2 + 4'd1;
            w_pulse_nx = 1'b1;
            w_hold_nx  = '0;
            w_state_nx = (w_g2_nx == GAMES_WIN) ? SET_DONE : GAME_HOLD;
          end
        end
      end
      GAME_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_hold_nx  = '0;
          w_state_nx = PLAY;
        end else begin
          w_hold_nx = r_hold_cnt + 1'b1;
        end
      end
      SET_DONE: begin
        if (r_blink_cnt == BLINK_LAST) begin
          w_blink_cnt_nx = '0;
          w_blink_nx     = ~r_blink;
        end else begin
          w_blink_cnt_nx = r_blink_cnt + 1'b1;
        end
      end
      default: w_state_nx = PLAY;
    endcase
  end

  // Edge history resets high so a button held through reset never scores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= PLAY;
      r_prev1      <= 1'b1;
      r_prev2      <= 1'b1;
      r_p1         <= PT_0;
      r_p2         <= PT_0;
      r_g1         <= 4'd0;
      r_g2         <= 4'd0;
      r_hold_cnt   <= '0;
      r_blink_cnt  <= '0;
      r_blink      <= 1'b0;
      r_game_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_prev1      <= point1;
      r_prev2      <= point2;
      r_p1         <= w_p1_nx;
      r_p2         <= w_p2_nx;
      r_g1         <= w_g1_nx;
      r_g2         <= w_g2_nx;
      r_hold_cnt   <= w_hold_nx;
      r_blink_cnt  <= w_blink_cnt_nx;
      r_blink      <= w_blink_nx;
      r_game_pulse <= w_pulse_nx;
    end
  end

  tennis_digit_enc u_p1_enc (
    .i_pt    (r_p1),
    .i_val   (r_g1),
    .o_pt_hi (w_p1_hi),
    .o_pt_lo (w_p1_lo),
    .o_val   (w_g1_seg)
  );

  tennis_digit_enc u_p2_enc (
    .i_pt    (r_p2),
    .i_val   (r_g2),
    .o_pt_hi (w_p2_hi),
    .o_pt_lo (w_p2_lo),
    .o_val   (w_g2_seg)
  );

  always_comb begin
    w_an     = AN_NORMAL;
    w_winner = 2'b00;
    if (r_state == SET_DONE) begin
      w_winner = (r_g1 == GAMES_WIN) ? 2'b01 : 2'b10;
      if (r_blink) begin
        if (r_g1 == GAMES_WIN) w_an[7] = 1'b0;
        else                   w_an[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_data <= '0;
      r_an_en    <= 8'd0;
      r_winner   <= 2'b00;
    end else begin
      r_seg_data <= {w_g1_seg, BLANK, w_p1_hi, w_p1_lo, w_p2_hi, w_p2_lo, BLANK, w_g2_seg};
      r_an_en    <= w_an;
      r_winner   <= w_winner;
    end
  end

  assign seg_data   = r_seg_data;
  assign an_en      = r_an_en;
  assign winner     = r_winner;
  assign game_pulse = r_game_pulse;

endmodule
